// File: rtl/fake_noc_store_src_if.sv
// noc0 request/response channel bundle between the fake store source and its sink.
// Also carries the local NoC field layout shared by the source and its harness.

`ifndef FAKE_NOC_STORE_SRC_DEFINES
`define FAKE_NOC_STORE_SRC_DEFINES
`define NOC_DATA_WIDTH          128
`define NOC_CHIPID_WIDTH        8
`define NOC_X_WIDTH             8
`define NOC_Y_WIDTH             8
`define NOC_FBITS_WIDTH         4
`define MSG_LENGTH_WIDTH        8
`define MSG_TYPE_WIDTH          8
`define MSG_DATA_SIZE_WIDTH     3
`define MSG_TYPE_STORE_MEM      8'd19
`define MSG_TYPE_STORE_MEM_ACK  8'd24
`define NOC_HDR_DST_CHIP        127:120
`define NOC_HDR_DST_X           119:112
`define NOC_HDR_DST_Y           111:104
`define NOC_HDR_FBITS           103:100
`define NOC_HDR_MSG_LEN         99:92
`define NOC_HDR_MSG_TYPE        91:84
`define NOC_HDR_SRC_CHIP        83:76
`define NOC_HDR_SRC_X           75:68
`define NOC_HDR_SRC_Y           67:60
`define NOC_HDR_SRC_FBITS       59:56
`define NOC_HDR_DATA_SIZE       55:53
`endif

interface fake_noc_store_src_if;
  logic                       src_noc0_val;
  logic [`NOC_DATA_WIDTH-1:0] src_noc0_data;
  logic                       noc0_src_rdy;
  logic                       noc0_src_val;
  logic [`NOC_DATA_WIDTH-1:0] noc0_src_data;
  logic                       src_noc0_rdy;

  modport master (
    output src_noc0_val, src_noc0_data, src_noc0_rdy,
    input  noc0_src_rdy, noc0_src_val, noc0_src_data
  );

  modport slave (
    input  src_noc0_val, src_noc0_data, src_noc0_rdy,
    output noc0_src_rdy, noc0_src_val, noc0_src_data
  );
endinterface

// File: rtl/fake_noc_store_src.sv
// Fake noc0 store-request generator: header + payload flits, one STORE_MEM_ACK per request.
// Optional latency statistics (lat_max/lat_sum) when FAKE_NOC_SRC_LAT_STATS_EN is defined.

module fake_noc_store_src #(
  parameter int unsigned SRC_CHIP_ID = 0,
  parameter int unsigned SRC_X       = 0,
  parameter int unsigned SRC_Y       = 0,
  parameter int unsigned SRC_FBITS   = 0,
  parameter int unsigned DATA_SIZE   = 0,
  parameter int unsigned REQ_CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_start,
  input  logic [REQ_CNT_W-1:0]          cfg_num_reqs,
  input  logic [`MSG_LENGTH_WIDTH-1:0]  cfg_msg_len,
  input  logic [`NOC_CHIPID_WIDTH-1:0]  cfg_dst_chip_id,
  input  logic [`NOC_X_WIDTH-1:0]       cfg_dst_x,
  input  logic [`NOC_Y_WIDTH-1:0]       cfg_dst_y,
  fake_noc_store_src_if.master          noc,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [REQ_CNT_W-1:0]          reqs_sent,
  output logic [REQ_CNT_W-1:0]          acks_rxed
`ifdef FAKE_NOC_SRC_LAT_STATS_EN
  ,
  output logic [31:0]                   lat_max,
  output logic [31:0]                   lat_sum
`endif
);

  localparam logic [`NOC_CHIPID_WIDTH-1:0]    SrcChip  = `NOC_CHIPID_WIDTH'(SRC_CHIP_ID);
  localparam logic [`NOC_X_WIDTH-1:0]         SrcX     = `NOC_X_WIDTH'(SRC_X);
  localparam logic [`NOC_Y_WIDTH-1:0]         SrcY     = `NOC_Y_WIDTH'(SRC_Y);
  localparam logic [`NOC_FBITS_WIDTH-1:0]     SrcFbits = `NOC_FBITS_WIDTH'(SRC_FBITS);
  localparam logic [`MSG_DATA_SIZE_WIDTH-1:0] DataSz   = `MSG_DATA_SIZE_WIDTH'(DATA_SIZE);

  typedef enum logic [2:0] {StIdle, StSendHdr, StSendPayload, StWaitResp, StDone} state_e;

  state_e                         state_q, state_d;
  logic [REQ_CNT_W-1:0]           num_reqs_q, num_reqs_d;
  logic [REQ_CNT_W-1:0]           reqs_q, reqs_d;
  logic [REQ_CNT_W-1:0]           acks_q, acks_d;
  logic [REQ_CNT_W-1:0]           req_idx_q, req_idx_d;
  logic [`MSG_LENGTH_WIDTH-1:0]   msg_len_q, msg_len_d;
  logic [`MSG_LENGTH_WIDTH-1:0]   flit_idx_q, flit_idx_d;
  logic [`NOC_CHIPID_WIDTH-1:0]   dst_chip_q, dst_chip_d;
  logic [`NOC_X_WIDTH-1:0]        dst_x_q, dst_x_d;
  logic [`NOC_Y_WIDTH-1:0]        dst_y_q, dst_y_d;
  logic                           err_q, err_d;
  logic [`NOC_DATA_WIDTH-1:0]     hdr_flit;
  logic                           resp_bad;
  logic                           start_acc, hdr_hs, resp_hs;
  logic                           unused_resp;

  assign start_acc = (state_q == StIdle) && cfg_start;
  assign hdr_hs    = (state_q == StSendHdr) && noc.noc0_src_rdy;
  assign resp_hs   = (state_q == StWaitResp) && noc.noc0_src_val;

  always_comb begin
    hdr_flit                     = '0;
    hdr_flit[`NOC_HDR_DST_CHIP]  = dst_chip_q;
    hdr_flit[`NOC_HDR_DST_X]     = dst_x_q;
    hdr_flit[`NOC_HDR_DST_Y]     = dst_y_q;
    hdr_flit[`NOC_HDR_MSG_LEN]   = msg_len_q;
    hdr_flit[`NOC_HDR_MSG_TYPE]  = `MSG_TYPE_STORE_MEM;
    hdr_flit[`NOC_HDR_SRC_CHIP]  = SrcChip;
    hdr_flit[`NOC_HDR_SRC_X]     = SrcX;
    hdr_flit[`NOC_HDR_SRC_Y]     = SrcY;
    hdr_flit[`NOC_HDR_SRC_FBITS] = SrcFbits;
    hdr_flit[`NOC_HDR_DATA_SIZE] = DataSz;
  end

  // The ack comes back addressed to us, so its dst fields must echo our src identity.
  assign resp_bad = (noc.noc0_src_data[`NOC_HDR_MSG_TYPE]  != `MSG_TYPE_STORE_MEM_ACK) ||
                    (noc.noc0_src_data[`NOC_HDR_MSG_LEN]   != '0) ||
                    (noc.noc0_src_data[`NOC_HDR_DST_CHIP]  != SrcChip) ||
                    (noc.noc0_src_data[`NOC_HDR_DST_X]     != SrcX) ||
                    (noc.noc0_src_data[`NOC_HDR_DST_Y]     != SrcY) ||
                    (noc.noc0_src_data[`NOC_HDR_FBITS]     != SrcFbits) ||
                    (noc.noc0_src_data[`NOC_HDR_DATA_SIZE] != DataSz);

  assign unused_resp = ^{noc.noc0_src_data[83:56], noc.noc0_src_data[52:0]};

  always_comb begin
    state_d           = state_q;
    num_reqs_d        = num_reqs_q;
    reqs_d            = reqs_q;
    acks_d            = acks_q;
    req_idx_d         = req_idx_q;
    msg_len_d         = msg_len_q;
    flit_idx_d        = flit_idx_q;
    dst_chip_d        = dst_chip_q;
    dst_x_d           = dst_x_q;
    dst_y_d           = dst_y_q;
    err_d             = err_q;
    noc.src_noc0_val  = 1'b0;
    noc.src_noc0_data = '0;
    noc.src_noc0_rdy  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          num_reqs_d = cfg_num_reqs;
          msg_len_d  = cfg_msg_len;
          dst_chip_d = cfg_dst_chip_id;
          dst_x_d    = cfg_dst_x;
          dst_y_d    = cfg_dst_y;
          reqs_d     = '0;
          acks_d     = '0;
          req_idx_d  = '0;
          err_d      = 1'b0;
          state_d    = (cfg_num_reqs == '0) ? StDone : StSendHdr;
        end
      end
      StSendHdr: begin
        noc.src_noc0_val  = 1'b1;
        noc.src_noc0_data = hdr_flit;
        if (noc.noc0_src_rdy) begin
          if (msg_len_q == '0) begin
            reqs_d  = reqs_q + 1'b1;
            state_d = StWaitResp;
          end else begin
            flit_idx_d = '0;
            state_d    = StSendPayload;
          end
        end
      end
      StSendPayload: begin
        noc.src_noc0_val  = 1'b1;
        noc.src_noc0_data = `NOC_DATA_WIDTH'({16'(req_idx_q), 16'(flit_idx_q)});
        if (noc.noc0_src_rdy) begin
          flit_idx_d = flit_idx_q + 1'b1;
          if (flit_idx_q == msg_len_q - 1'b1) begin
            reqs_d  = reqs_q + 1'b1;
            state_d = StWaitResp;
          end
        end
      end
      StWaitResp: begin
        noc.src_noc0_rdy = 1'b1;
        if (noc.noc0_src_val) begin
          acks_d = acks_q + 1'b1;
          if (resp_bad) err_d = 1'b1;
          if (REQ_CNT_W'(acks_q + 1'b1) == num_reqs_q) begin
            state_d = StDone;
          end else begin
            req_idx_d = req_idx_q + 1'b1;
            state_d   = StSendHdr;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      num_reqs_q <= '0;
      reqs_q     <= '0;
      acks_q     <= '0;
      req_idx_q  <= '0;
      msg_len_q  <= '0;
      flit_idx_q <= '0;
      dst_chip_q <= '0;
      dst_x_q    <= '0;
      dst_y_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_reqs_q <= num_reqs_d;
      reqs_q     <= reqs_d;
      acks_q     <= acks_d;
      req_idx_q  <= req_idx_d;
      msg_len_q  <= msg_len_d;
      flit_idx_q <= flit_idx_d;
      dst_chip_q <= dst_chip_d;
      dst_x_q    <= dst_x_d;
      dst_y_q    <= dst_y_d;
      err_q      <= err_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign err       = err_q;
  assign reqs_sent = reqs_q;
  assign acks_rxed = acks_q;

`ifdef FAKE_NOC_SRC_LAT_STATS_EN
  logic [31:0] lat_cnt_q, lat_cnt_d;
  logic [31:0] lat_max_q, lat_max_d;
  logic [31:0] lat_sum_q, lat_sum_d;
  logic [32:0] lat_sum_wide;

  assign lat_sum_wide = {1'b0, lat_sum_q} + {1'b0, lat_cnt_q};

  // Timer is loaded with 1 on the header handshake, so it reads the elapsed cycles at the ack.
  always_comb begin
    lat_cnt_d = (lat_cnt_q == '1) ? lat_cnt_q : lat_cnt_q + 32'd1;
    lat_max_d = lat_max_q;
    lat_sum_d = lat_sum_q;
    if (start_acc) begin
      lat_max_d = '0;
      lat_sum_d = '0;
    end
    if (hdr_hs) lat_cnt_d = 32'd1;
    if (resp_hs) begin
      if (lat_cnt_q > lat_max_q) lat_max_d = lat_cnt_q;
      lat_sum_d = lat_sum_wide[32] ? '1 : lat_sum_wide[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt_q <= '0;
      lat_max_q <= '0;
      lat_sum_q <= '0;
    end else begin
      lat_cnt_q <= lat_cnt_d;
      lat_max_q <= lat_max_d;
      lat_sum_q <= lat_sum_d;
    end
  end

  assign lat_max = lat_max_q;
  assign lat_sum = lat_sum_q;
`endif

endmodule

// File: tb/tb_fake_noc_store_src.sv
// Directed bench for fake_noc_store_src with a small store-sink model on noc0.
// Build with FAKE_NOC_SRC_LAT_STATS_EN defined to also cover the latency statistics.

module tb_fake_noc_store_src;

  localparam logic [127:0] Hdr4   = 128'h0705_0600_4130_3010_2560_0000_0000_0000;
  localparam logic [127:0] Hdr0   = 128'h0705_0600_0130_3010_2560_0000_0000_0000;
  localparam logic [127:0] AckOk  = 128'h0301_0250_0180_0000_0060_0000_0000_0000;
  localparam logic [127:0] AckBad = 128'h0301_0250_0130_0000_0060_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_num_reqs = '0;
  logic [7:0]  cfg_msg_len = '0;
  logic [7:0]  cfg_dst_chip_id = 8'd7;
  logic [7:0]  cfg_dst_x = 8'd5;
  logic [7:0]  cfg_dst_y = 8'd6;
  logic        busy, done, err;
  logic [15:0] reqs_sent, acks_rxed;
`ifdef FAKE_NOC_SRC_LAT_STATS_EN
  logic [31:0] lat_max, lat_sum;
`endif

  fake_noc_store_src_if noc_if ();

  fake_noc_store_src #(
    .SRC_CHIP_ID(3), .SRC_X(1), .SRC_Y(2), .SRC_FBITS(5), .DATA_SIZE(3), .REQ_CNT_W(16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_start       (cfg_start),
    .cfg_num_reqs    (cfg_num_reqs),
    .cfg_msg_len     (cfg_msg_len),
    .cfg_dst_chip_id (cfg_dst_chip_id),
    .cfg_dst_x       (cfg_dst_x),
    .cfg_dst_y       (cfg_dst_y),
    .noc             (noc_if),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .reqs_sent       (reqs_sent),
    .acks_rxed       (acks_rxed)
`ifdef FAKE_NOC_SRC_LAT_STATS_EN
    ,
    .lat_max         (lat_max),
    .lat_sum         (lat_sum)
`endif
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [127:0] flits[$];
  int           val_cycles = 0;
  int           stab_err = 0;
  int           resp_cnt = 0;
  int           bad_resp_idx = -1;
  int           resp_delay = 0;
  bit           stall_mode = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sink model: drives ready/response just after posedge, observes at negedge.
  initial begin : sink
    bit           prev_stall;
    logic [127:0] prev_data;
    int           remain;
    bit           in_req;
    bit           resp_pending;
    bit           resp_taken;
    int           resp_wait;
    prev_stall = 0; prev_data = '0; remain = 0; in_req = 0;
    resp_pending = 0; resp_taken = 0; resp_wait = 0;
    noc_if.noc0_src_rdy  = 1'b0;
    noc_if.noc0_src_val  = 1'b0;
    noc_if.noc0_src_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_stall = 0; in_req = 0; resp_pending = 0; resp_taken = 0;
        noc_if.noc0_src_rdy  = 1'b0;
        noc_if.noc0_src_val  = 1'b0;
        noc_if.noc0_src_data = '0;
        continue;
      end
      if (resp_taken) begin
        noc_if.noc0_src_val = 1'b0;
        resp_taken = 0;
      end else if (resp_pending && !noc_if.noc0_src_val) begin
        if (resp_wait == 0) begin
          noc_if.noc0_src_val  = 1'b1;
          noc_if.noc0_src_data = (resp_cnt == bad_resp_idx) ? AckBad : AckOk;
        end else begin
          resp_wait--;
        end
      end
      noc_if.noc0_src_rdy = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (!rst_n) continue;
      if (noc_if.src_noc0_val) begin
        val_cycles++;
        if (prev_stall && noc_if.src_noc0_data !== prev_data) stab_err++;
      end else if (prev_stall) begin
        stab_err++;
      end
      prev_stall = noc_if.src_noc0_val && !noc_if.noc0_src_rdy;
      prev_data  = noc_if.src_noc0_data;
      if (noc_if.src_noc0_val && noc_if.noc0_src_rdy) begin
        flits.push_back(noc_if.src_noc0_data);
        if (!in_req) begin
          remain = int'(noc_if.src_noc0_data[99:92]);
          in_req = 1;
        end else begin
          remain--;
        end
        if (remain == 0) begin
          in_req       = 0;
          resp_pending = 1;
          resp_wait    = stall_mode ? int'($urandom_range(0, 3)) : resp_delay;
        end
      end
      if (noc_if.noc0_src_val && noc_if.src_noc0_rdy) begin
        resp_taken   = 1;
        resp_pending = 0;
        resp_cnt++;
      end
    end
  end

  task automatic pulse_start(input int num, input int len);
    cfg_num_reqs = 16'(num);
    cfg_msg_len  = 8'(len);
    flits.delete();
    val_cycles = 0;
    stab_err   = 0;
    resp_cnt   = 0;
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  // Runs one sequence; reports done-pulse count and negedges from start edge to first done.
  task automatic run_seq(input int num, input int len, input bit stall, input bit poke_busy,
                         output int done_cnt, output int cyc_to_done);
    stall_mode = stall;
    pulse_start(num, len);
    done_cnt    = 0;
    cyc_to_done = -1;
    for (int i = 1; i <= 4000; i++) begin
      if (done) begin
        done_cnt++;
        if (cyc_to_done < 0) cyc_to_done = i;
      end
      if (poke_busy && i == 6) begin
        cfg_num_reqs = 16'd1;
        cfg_msg_len  = 8'd0;
        cfg_start    = 1'b1;
      end
      if (i == 7) cfg_start = 1'b0;
      if (!busy && cyc_to_done >= 0) break;
      @(negedge clk);
    end
    if (cyc_to_done < 0) $display("FAIL run_seq_timeout: got no done, expected done");
    stall_mode = 1'b0;
  endtask

  initial begin : main
    int dcnt;
    int dcyc;
    bit seen;

    repeat (3) @(negedge clk);
    check_eq("reset_outs", {noc_if.src_noc0_val, noc_if.src_noc0_rdy, busy, done, err}, '0);
    check_eq("reset_cnts", {reqs_sent, acks_rxed}, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three requests of four payload flits, sink always ready.
    run_seq(3, 4, 0, 0, dcnt, dcyc);
    check_eq("t1_flits", flits.size(), 15);
    check_eq("t1_hdr0", flits[0], Hdr4);
    check_eq("t1_hdr1", flits[5], Hdr4);
    check_eq("t1_pl_r0f0", flits[1], 128'h0);
    check_eq("t1_pl_r2f3", flits[14], 128'h0002_0003);
    check_eq("t1_counts", {reqs_sent, acks_rxed}, {16'd3, 16'd3});
    check_eq("t1_done", dcnt, 1);
    check_eq("t1_err", err, 1'b0);

    // Header-only requests.
    run_seq(2, 0, 0, 0, dcnt, dcyc);
    check_eq("t2_flits", flits.size(), 2);
    check_eq("t2_hdr", flits[1], Hdr0);
    check_eq("t2_counts", {reqs_sent, acks_rxed}, {16'd2, 16'd2});
    check_eq("t2_err", err, 1'b0);

    // Random back-pressure and response delay.
    run_seq(5, 7, 1, 0, dcnt, dcyc);
    check_eq("t3_flits", flits.size(), 40);
    check_eq("t3_pl_r2f3", flits[20], 128'h0002_0003);
    check_eq("t3_pl_r4f6", flits[39], 128'h0004_0006);
    check_eq("t3_stable", stab_err, 0);
    check_eq("t3_counts", {reqs_sent, acks_rxed}, {16'd5, 16'd5});
    check_eq("t3_err", err, 1'b0);

    // Zero requests: immediate done, nothing on the request channel.
    run_seq(0, 3, 0, 0, dcnt, dcyc);
    check_eq("t4_val_cycles", val_cycles, 0);
    check_eq("t4_done_lat", dcyc, 1);
    check_eq("t4_done_cnt", dcnt, 1);
    check_eq("t4_counts", {reqs_sent, acks_rxed}, '0);

    // Second response carries the wrong type; a start while busy must be ignored.
    bad_resp_idx = 1;
    run_seq(3, 2, 0, 1, dcnt, dcyc);
    bad_resp_idx = -1;
    check_eq("t5_err", err, 1'b1);
    check_eq("t5_counts", {reqs_sent, acks_rxed}, {16'd3, 16'd3});
    check_eq("t5_flits", flits.size(), 9);
    @(negedge clk);
    check_eq("t5_err_sticky", {busy, err}, 2'b01);

    // Reset in the middle of the second request's payload.
    pulse_start(3, 4);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (flits.size() >= 7) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("t6_reached", seen, 1'b1);
    check_eq("t6_pre_rst", {noc_if.src_noc0_val, reqs_sent}, {1'b1, 16'd1});
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_outs", {noc_if.src_noc0_val, noc_if.src_noc0_rdy, busy, done, err}, '0);
    check_eq("t6_rst_cnts", {reqs_sent, acks_rxed}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_seq(2, 1, 0, 0, dcnt, dcyc);
    check_eq("t6_after_flits", flits.size(), 4);
    check_eq("t6_after_counts", {reqs_sent, acks_rxed, 15'd0, err}, {16'd2, 16'd2, 16'd0});

`ifdef FAKE_NOC_SRC_LAT_STATS_EN
    // Header-only requests with the ack handshake 4 cycles after the header handshake.
    resp_delay = 3;
    run_seq(2, 0, 0, 0, dcnt, dcyc);
    resp_delay = 0;
    check_eq("lat_max", lat_max, 32'd4);
    check_eq("lat_sum", lat_sum, 32'd8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
